csr_exec_unit: RTL and testbench

- Downstream consumer of the renamer-to-CSRU handoff: takes one CSR instruction from the renamer plus the per-cycle graduation vector.
- Holds the CSR until its active-list tag reaches the head, then performs the read-modify-write on a small machine-mode CSR file and writes the old value back to the physical register file.
- Maintains mcycle and minstret; minstret is driven by the graduation vector.

---
 rtl/csr_exec_pkg.sv | 38 +++
 rtl/csr_exec_unit_counter.sv | 45 ++++
 rtl/csr_exec_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_csr_exec_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_exec_pkg.sv
// ---------------------------------------------------------------------------
// csr_exec_pkg
// Shared definitions for the CSR execution unit:
//   - csr_op_t      : CSR operation encoding carried from the renamer
//   - csr_state_t   : handshake / execution FSM states
//   - CSR_*         : machine-mode CSR addresses implemented by the unit
//   - MSTATUS_WMASK : bits of mstatus that software may write (MIE, MPIE)
// ---------------------------------------------------------------------------
package csr_exec_pkg;

  typedef enum logic [1:0] {
    CSR_OP_ILL = 2'd0,
    CSR_OP_RW  = 2'd1,
    CSR_OP_RS  = 2'd2,
    CSR_OP_RC  = 2'd3
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HEAD = 2'd1,
    ST_EXEC      = 2'd2,
    ST_WB        = 2'd3
  } csr_state_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;

endpackage

// File: rtl/csr_exec_unit_counter.sv
// ---------------------------------------------------------------------------
// csr_counter64
// 64-bit free-running event counter with independently writable halves.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (counter clears to 0)
//   inc        : amount added this cycle
//   wr_lo      : load value[HALF_W-1:0] from wdata instead of incrementing
//   wr_hi      : load value[2*HALF_W-1:HALF_W] from wdata instead of incrementing
//   wdata      : write data for either half
//   value      : current count (pre-increment value of this cycle)
// ---------------------------------------------------------------------------
module csr_counter64
  import csr_exec_pkg::*;
#(
  parameter int HALF_W = 32,
  parameter int INC_W  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INC_W-1:0]    inc,
  input  logic                wr_lo,
  input  logic                wr_hi,
  input  logic [HALF_W-1:0]   wdata,
  output logic [2*HALF_W-1:0] value
);

  logic [2*HALF_W-1:0] count_q;

  // A software write to either half replaces that half, leaves the other one
  // alone and drops the increment for the cycle; otherwise count and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (wr_lo) begin
      count_q[HALF_W-1:0] <= wdata;
    end else if (wr_hi) begin
      count_q[2*HALF_W-1:HALF_W] <= wdata;
    end else begin
      count_q <= count_q + (2*HALF_W)'(inc);
    end
  end

  assign value = count_q;

endmodule

// File: rtl/csr_exec_unit.sv
// ---------------------------------------------------------------------------
// csr_exec_unit
// Executes one CSR instruction at a time. The instruction is accepted from the
// renamer, held until its active-list tag is at the head, then the
// read-modify-write is performed on the machine-mode CSR file and the old
// value is returned for the physical register file.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   csr_valid/csr_ready   : instruction handshake (ready only when idle)
//   csr_op, csr_addr      : operation (csr_op_t) and CSR address
//   csr_src               : rs1 value or zero-extended immediate
//   csr_dst_preg          : destination physical register
//   csr_al_tag            : active-list tag of the instruction
//   al_head_valid/tag     : current active-list head
//   commit_valid          : graduating slots this cycle (drives minstret)
//   flush                 : squash a held instruction
//   wb_valid              : one-cycle writeback / completion strobe
//   wb_preg, wb_data      : writeback register and old CSR value
//   wb_al_tag, wb_illegal : completion tag and illegal-instruction flag
// ---------------------------------------------------------------------------
module csr_exec_unit
  import csr_exec_pkg::*;
#(
  parameter int                XLEN            = 32,
  parameter int                NUM_OF_GRADUATE = 2,
  parameter int                PREG_W          = 6,
  parameter int                AL_TAG_W        = 5,
  parameter int unsigned       HART_ID         = 0,
  parameter logic [XLEN-1:0]   MTVEC_RESET     = 32'h0000_0100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       csr_valid,
  input  logic [1:0]                 csr_op,
  input  logic [11:0]                csr_addr,
  input  logic [XLEN-1:0]            csr_src,
  input  logic [PREG_W-1:0]          csr_dst_preg,
  input  logic [AL_TAG_W-1:0]        csr_al_tag,
  output logic                       csr_ready,
  input  logic                       al_head_valid,
  input  logic [AL_TAG_W-1:0]        al_head_tag,
  input  logic [NUM_OF_GRADUATE-1:0] commit_valid,
  input  logic                       flush,
  output logic                       wb_valid,
  output logic [PREG_W-1:0]          wb_preg,
  output logic [XLEN-1:0]            wb_data,
  output logic [AL_TAG_W-1:0]        wb_al_tag,
  output logic                       wb_illegal
);

  localparam int INST_INC_W = $clog2(NUM_OF_GRADUATE + 1);

  csr_state_t state_q, state_eff, state_next;

  csr_op_t           op_q;
  logic [11:0]       addr_q;
  logic [XLEN-1:0]   src_q;
  logic [PREG_W-1:0] preg_q;
  logic [AL_TAG_W-1:0] tag_q;

  logic [XLEN-1:0]   mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [2*XLEN-1:0] mcycle_val, minstret_val;

  logic              transfer, head_match, exec_now;
  logic [XLEN-1:0]   old_val, new_val;
  logic              mapped, do_write, illegal, wr_en;
  logic              cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
  logic [INST_INC_W-1:0] retire_cnt;

  assign csr_ready  = (state_q == ST_IDLE);
  assign transfer   = csr_valid && csr_ready;
  assign head_match = al_head_valid && (al_head_tag == tag_q);

  // EXEC is folded into the head-match cycle: the registered state never
  // holds EXEC, so that a head match in the cycle after acceptance yields
  // wb_valid in the following cycle. Flush beats a coincident head match.
  assign exec_now  = (state_q == ST_WAIT_HEAD) && head_match && !flush;
  assign state_eff = exec_now ? ST_EXEC : state_q;

  // Next-state decode from the effective state; flush only matters while
  // waiting for the head.
  always_comb begin
    state_next = state_eff;
    case (state_eff)
      ST_IDLE:      if (transfer) state_next = ST_WAIT_HEAD;
      ST_WAIT_HEAD: if (flush)    state_next = ST_IDLE;
      ST_EXEC:      state_next = ST_WB;
      ST_WB:        state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Capture the instruction on transfer; fields stay stable while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= CSR_OP_ILL;
      addr_q <= '0;
      src_q  <= '0;
      preg_q <= '0;
      tag_q  <= '0;
    end else if (transfer) begin
      op_q   <= csr_op_t'(csr_op);
      addr_q <= csr_addr;
      src_q  <= csr_src;
      preg_q <= csr_dst_preg;
      tag_q  <= csr_al_tag;
    end
  end

  // Read mux over the CSR map; counters return this cycle's pre-increment
  // value. Anything not listed is unmapped.
  always_comb begin
    old_val = '0;
    mapped  = 1'b1;
    case (addr_q)
      CSR_MSTATUS:   old_val = mstatus_q;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MCYCLE:    old_val = mcycle_val[XLEN-1:0];
      CSR_MCYCLEH:   old_val = mcycle_val[2*XLEN-1:XLEN];
      CSR_MINSTRET:  old_val = minstret_val[XLEN-1:0];
      CSR_MINSTRETH: old_val = minstret_val[2*XLEN-1:XLEN];
      CSR_MHARTID:   old_val = XLEN'(HART_ID);
      default:       mapped  = 1'b0;
    endcase
  end

  // Modify step. Set/clear with a zero mask is a pure read, which is what
  // makes reading a read-only CSR with RS/RC x0 legal.
  always_comb begin
    new_val  = old_val;
    do_write = 1'b0;
    case (op_q)
      CSR_OP_RW: begin
        new_val  = src_q;
        do_write = 1'b1;
      end
      CSR_OP_RS: begin
        new_val  = old_val | src_q;
        do_write = |src_q;
      end
      CSR_OP_RC: begin
        new_val  = old_val & ~src_q;
        do_write = |src_q;
      end
      default: begin
        new_val  = old_val;
        do_write = 1'b0;
      end
    endcase
  end

  assign illegal = !mapped || (op_q == CSR_OP_ILL) ||
                   (do_write && (addr_q[11:10] == 2'b11));
  assign wr_en   = exec_now && !illegal && do_write;

  assign cyc_wr_lo = wr_en && (addr_q == CSR_MCYCLE);
  assign cyc_wr_hi = wr_en && (addr_q == CSR_MCYCLEH);
  assign ins_wr_lo = wr_en && (addr_q == CSR_MINSTRET);
  assign ins_wr_hi = wr_en && (addr_q == CSR_MINSTRETH);

  // Plain CSR storage with per-register WARL masking applied on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (wr_en) begin
      case (addr_q)
        CSR_MSTATUS:  mstatus_q  <= new_val & XLEN'(MSTATUS_WMASK);
        CSR_MTVEC:    mtvec_q    <= {new_val[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch_q <= new_val;
        CSR_MEPC:     mepc_q     <= {new_val[XLEN-1:1], 1'b0};
        CSR_MCAUSE:   mcause_q   <= new_val;
        default:      ;
      endcase
    end
  end

  // Number of instructions graduating this cycle.
  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < NUM_OF_GRADUATE; i++) begin
      retire_cnt = retire_cnt + INST_INC_W'(commit_valid[i]);
    end
  end

  csr_counter64 #(
    .HALF_W (XLEN),
    .INC_W  (1)
  ) u_mcycle (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (1'b1),
    .wr_lo  (cyc_wr_lo),
    .wr_hi  (cyc_wr_hi),
    .wdata  (new_val),
    .value  (mcycle_val)
  );

  csr_counter64 #(
    .HALF_W (XLEN),
    .INC_W  (INST_INC_W)
  ) u_minstret (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (retire_cnt),
    .wr_lo  (ins_wr_lo),
    .wr_hi  (ins_wr_hi),
    .wdata  (new_val),
    .value  (minstret_val)
  );

  // Writeback register: loaded in the execute cycle, strobe lasts one cycle.
  // An illegal access completes with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_illegal <= 1'b0;
      wb_preg    <= '0;
      wb_data    <= '0;
      wb_al_tag  <= '0;
    end else if (exec_now) begin
      wb_valid   <= 1'b1;
      wb_illegal <= illegal;
      wb_preg    <= preg_q;
      wb_data    <= illegal ? '0 : old_val;
      wb_al_tag  <= tag_q;
    end else begin
      wb_valid   <= 1'b0;
      wb_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_exec_unit
// Self-checking bench for csr_exec_unit: directed vector table, hand-written
// counter and flush sequences, then randomized traffic against a reference
// model of the CSR file kept in plain variables.
// ---------------------------------------------------------------------------
module tb_csr_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic [5:0]  csr_dst_preg;
  logic [4:0]  csr_al_tag;
  logic        csr_ready;
  logic        al_head_valid;
  logic [4:0]  al_head_tag;
  logic [1:0]  commit_valid;
  logic        flush;
  logic        wb_valid;
  logic [5:0]  wb_preg;
  logic [31:0] wb_data;
  logic [4:0]  wb_al_tag;
  logic        wb_illegal;

  csr_exec_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_valid     (csr_valid),
    .csr_op        (csr_op),
    .csr_addr      (csr_addr),
    .csr_src       (csr_src),
    .csr_dst_preg  (csr_dst_preg),
    .csr_al_tag    (csr_al_tag),
    .csr_ready     (csr_ready),
    .al_head_valid (al_head_valid),
    .al_head_tag   (al_head_tag),
    .commit_valid  (commit_valid),
    .flush         (flush),
    .wb_valid      (wb_valid),
    .wb_preg       (wb_preg),
    .wb_data       (wb_data),
    .wb_al_tag     (wb_al_tag),
    .wb_illegal    (wb_illegal)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference CSR state.
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;
  logic        p_cyc_lo, p_cyc_hi, p_ins_lo, p_ins_hi;
  logic [31:0] p_data;
  logic        commit_rand;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    int          delay;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[14];

  logic [11:0] addr_pool[14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14,
                                 12'h7C0, 12'h301, 12'hB01, 12'hF11};

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mstatus  = '0;
    m_mtvec    = 32'h0000_0100;
    m_mscratch = '0;
    m_mepc     = '0;
    m_mcause   = '0;
    m_cyc      = '0;
    m_ins      = '0;
    p_cyc_lo = 0; p_cyc_hi = 0; p_ins_lo = 0; p_ins_hi = 0;
    p_data   = '0;
  endtask

  // One clock cycle: advance the counter model at the rising edge, then
  // return at the falling edge where outputs are sampled and inputs driven.
  task automatic tick();
    @(posedge clk);
    if (p_cyc_lo)      m_cyc = {m_cyc[63:32], p_data};
    else if (p_cyc_hi) m_cyc = {p_data, m_cyc[31:0]};
    else               m_cyc = m_cyc + 64'd1;
    if (p_ins_lo)      m_ins = {m_ins[63:32], p_data};
    else if (p_ins_hi) m_ins = {p_data, m_ins[31:0]};
    else               m_ins = m_ins + 64'($countones(commit_valid));
    p_cyc_lo = 0; p_cyc_hi = 0; p_ins_lo = 0; p_ins_hi = 0;
    @(negedge clk);
    if (commit_rand) commit_valid = 2'($urandom);
  endtask

  task automatic model_read(input logic [11:0] addr, output logic ok,
                            output logic [31:0] val);
    ok  = 1'b1;
    val = '0;
    case (addr)
      12'h300: val = m_mstatus;
      12'h305: val = m_mtvec;
      12'h340: val = m_mscratch;
      12'h341: val = m_mepc;
      12'h342: val = m_mcause;
      12'hB00: val = m_cyc[31:0];
      12'hB80: val = m_cyc[63:32];
      12'hB02: val = m_ins[31:0];
      12'hB82: val = m_ins[63:32];
      12'hF14: val = 32'd0;
      default: ok = 1'b0;
    endcase
  endtask

  // Architectural effect of one CSR instruction at the moment it executes.
  task automatic model_exec(input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] src, output logic [31:0] exp_d,
                            output logic exp_i);
    logic        ok, wr;
    logic [31:0] old, nv;
    model_read(addr, ok, old);
    wr = (op == 2'd1) || ((op != 2'd0) && (src != 0));
    nv = (op == 2'd1) ? src : (op == 2'd2) ? (old | src) : (old & ~src);
    exp_i = !ok || (op == 2'd0) || (wr && (addr[11:10] == 2'b11));
    exp_d = exp_i ? 32'd0 : old;
    if (!exp_i && wr) begin
      p_data = nv;
      case (addr)
        12'h300: m_mstatus  = nv & 32'h88;
        12'h305: m_mtvec    = nv & 32'hFFFF_FFFC;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & 32'hFFFF_FFFE;
        12'h342: m_mcause   = nv;
        12'hB00: p_cyc_lo = 1;
        12'hB80: p_cyc_hi = 1;
        12'hB02: p_ins_lo = 1;
        12'hB82: p_ins_hi = 1;
        default: ;
      endcase
    end
  endtask

  // Issue one CSR instruction, hold the head away for 'delay' cycles, let it
  // reach the head, and check the handshake and writeback timing.
  task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr,
                               input logic [31:0] src, input int delay,
                               output logic [31:0] got_d, output logic got_i,
                               output logic [31:0] exp_d, output logic exp_i);
    logic [4:0] tag;
    logic [5:0] preg;
    tag  = 5'($urandom);
    preg = 6'($urandom);
    checkOutput("ready_idle", csr_ready, 1);
    csr_valid = 1; csr_op = op; csr_addr = addr; csr_src = src;
    csr_dst_preg = preg; csr_al_tag = tag;
    al_head_valid = 0; al_head_tag = tag;
    tick();
    csr_valid = 0; csr_op = 2'($urandom); csr_addr = 12'($urandom);
    csr_src = $urandom; csr_dst_preg = 6'($urandom); csr_al_tag = 5'($urandom);
    checkOutput("busy_after_accept", csr_ready, 0);
    for (int i = 0; i < delay; i++) begin
      if ($urandom_range(1) == 1) begin
        al_head_valid = 1; al_head_tag = tag + 5'd1;
      end else begin
        al_head_valid = 0; al_head_tag = tag;
      end
      tick();
      checkOutput("wait_no_wb", wb_valid, 0);
      checkOutput("wait_busy", csr_ready, 0);
    end
    al_head_valid = 1; al_head_tag = tag;
    model_exec(op, addr, src, exp_d, exp_i);
    tick();
    al_head_valid = 0;
    checkOutput("wb_valid_on", wb_valid, 1);
    checkOutput("wb_preg", wb_preg, preg);
    checkOutput("wb_al_tag", wb_al_tag, tag);
    checkOutput("wb_busy", csr_ready, 0);
    got_d = wb_data;
    got_i = wb_illegal;
    tick();
    checkOutput("wb_valid_off", wb_valid, 0);
    checkOutput("ready_return", csr_ready, 1);
  endtask

  // Accept an RW to mscratch, keep it off the head, then flush it.
  task automatic flushSeq(input logic coincident);
    logic [4:0] tag;
    tag = 5'($urandom);
    csr_valid = 1; csr_op = 2'd1; csr_addr = 12'h340; csr_src = 32'h1111_2222;
    csr_dst_preg = 6'd9; csr_al_tag = tag;
    tick();
    csr_valid = 0;
    for (int i = 0; i < 5; i++) begin
      al_head_valid = 1; al_head_tag = tag + 5'd3;
      tick();
      checkOutput("flush_wait_no_wb", wb_valid, 0);
    end
    flush = 1;
    al_head_tag = coincident ? tag : tag + 5'd3;
    tick();
    flush = 0; al_head_valid = 0;
    checkOutput("flush_ready", csr_ready, 1);
    checkOutput("flush_no_wb", wb_valid, 0);
    tick();
    checkOutput("flush_still_no_wb", wb_valid, 0);
  endtask

  logic [31:0] gd, ed;
  logic        gi, ei;

  initial begin
    vecs[0]  = '{2'd1, 12'h340, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{2'd2, 12'h340, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{2'd2, 12'h300, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0};
    vecs[3]  = '{2'd3, 12'h300, 32'h8,         2, 32'h0000_0088, 1'b0};
    vecs[4]  = '{2'd2, 12'h300, 32'h0,         0, 32'h0000_0080, 1'b0};
    vecs[5]  = '{2'd1, 12'hF14, 32'h1,         0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{2'd1, 12'h7C0, 32'h5,         3, 32'h0000_0000, 1'b1};
    vecs[7]  = '{2'd2, 12'hF14, 32'h0,         0, 32'h0000_0000, 1'b0};
    vecs[8]  = '{2'd0, 12'h340, 32'h1234_5678, 0, 32'h0000_0000, 1'b1};
    vecs[9]  = '{2'd2, 12'h340, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{2'd1, 12'h305, 32'h0000_1237, 0, 32'h0000_0100, 1'b0};
    vecs[11] = '{2'd2, 12'h305, 32'h0,         1, 32'h0000_1234, 1'b0};
    vecs[12] = '{2'd1, 12'h341, 32'h0000_0003, 0, 32'h0000_0000, 1'b0};
    vecs[13] = '{2'd3, 12'h341, 32'h0,         0, 32'h0000_0002, 1'b0};

    rst_n = 0; csr_valid = 0; csr_op = 0; csr_addr = 0; csr_src = 0;
    csr_dst_preg = 0; csr_al_tag = 0; al_head_valid = 0; al_head_tag = 0;
    commit_valid = 0; flush = 0; commit_rand = 0;
    model_reset();

    #1;
    checkOutput("reset_wb_valid", wb_valid, 0);
    checkOutput("reset_wb_illegal", wb_illegal, 0);
    checkOutput("reset_wb_data", wb_data, 0);
    checkOutput("reset_wb_preg", wb_preg, 0);
    checkOutput("reset_wb_al_tag", wb_al_tag, 0);
    checkOutput("reset_ready", csr_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].src, vecs[i].delay,
                    gd, gi, ed, ei);
      checkOutput($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_illegal", i), gi, vecs[i].exp_ill);
    end

    flushSeq(1'b0);
    flushSeq(1'b1);
    applyStimulus(2'd2, 12'h340, 32'h0, 0, gd, gi, ed, ei);
    checkOutput("mscratch_after_flush", gd, 32'hDEAD_BEEF);

    applyStimulus(2'd1, 12'hB00, 32'd5, 0, gd, gi, ed, ei);
    applyStimulus(2'd2, 12'hB00, 32'd0, 0, gd, gi, ed, ei);
    checkOutput("mcycle_read1", gd, 32'd7);
    applyStimulus(2'd2, 12'hB00, 32'd0, 0, gd, gi, ed, ei);
    checkOutput("mcycle_read2", gd, 32'd10);

    applyStimulus(2'd1, 12'hB02, 32'd0, 0, gd, gi, ed, ei);
    applyStimulus(2'd1, 12'hB82, 32'd0, 0, gd, gi, ed, ei);
    commit_valid = 2'b11;
    repeat (10) tick();
    commit_valid = 2'b00;
    applyStimulus(2'd2, 12'hB02, 32'd0, 0, gd, gi, ed, ei);
    checkOutput("minstret_20", gd, 32'd20);
    applyStimulus(2'd1, 12'hB02, 32'hFFFF_FFFF, 0, gd, gi, ed, ei);
    commit_valid = 2'b01;
    tick();
    commit_valid = 2'b00;
    applyStimulus(2'd2, 12'hB82, 32'd0, 0, gd, gi, ed, ei);
    checkOutput("minstreth_carry", gd, 32'd1);
    applyStimulus(2'd2, 12'hB02, 32'd0, 0, gd, gi, ed, ei);
    checkOutput("minstret_wrap", gd, 32'd0);

    commit_rand = 1;
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  rop;
      logic [11:0] raddr;
      logic [31:0] rsrc;
      rop   = 2'($urandom);
      raddr = addr_pool[$urandom_range(13)];
      rsrc  = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      applyStimulus(rop, raddr, rsrc, $urandom_range(3), gd, gi, ed, ei);
      checkOutput($sformatf("rand%0d_data", i), gd, ed);
      checkOutput($sformatf("rand%0d_illegal", i), gi, ei);
    end
    commit_rand = 0;
    commit_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
